// File: rtl/clock_buf_ctrl.sv
// Divided-clock generator for a clock buffer: starts on a requester level,
// emits 50%-duty pulses of programmable half-period and never truncates a high phase on stop.
module clock_buf_ctrl #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_req,
    input  logic [DIV_W-1:0] div_sel,
    output logic             clk_out,
    output logic             en_ack,
    output logic             busy,
    output logic [7:0]       rise_cnt
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] hcnt_q, hcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clk_out_d;
    logic             en_ack_d;
    logic [CNT_W-1:0] rise_cnt_d;
    logic             hwrap;
    logic [DIV_W-1:0] hcnt_inc;

    assign hwrap    = (hcnt_q == div_q);
    assign hcnt_inc = hwrap ? '0 : hcnt_q + DIV_W'(1);
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q   <= '0;
            div_q    <= '0;
            clk_out  <= 1'b0;
            en_ack   <= 1'b0;
            rise_cnt <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            div_q    <= div_d;
            clk_out  <= clk_out_d;
            en_ack   <= en_ack_d;
            rise_cnt <= rise_cnt_d;
        end
    end

    // A rise is only launched while the request is still held; falls always complete.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        div_d      = div_q;
        clk_out_d  = clk_out;
        en_ack_d   = en_ack;
        rise_cnt_d = rise_cnt;
        case (state_q)
            ST_IDLE: begin
                if (en_req) begin
                    state_d    = ST_RUN;
                    div_d      = div_sel;
                    hcnt_d     = '0;
                    rise_cnt_d = '0;
                end
            end
            ST_RUN: begin
                hcnt_d = hcnt_inc;
                if (hwrap) begin
                    if (clk_out) begin
                        clk_out_d = 1'b0;
                    end else if (en_req) begin
                        clk_out_d  = 1'b1;
                        en_ack_d   = 1'b1;
                        rise_cnt_d = rise_cnt + CNT_W'(1);
                    end
                end
                if (!en_req) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                hcnt_d = hcnt_inc;
                if (!clk_out || hwrap) begin
                    state_d   = ST_IDLE;
                    clk_out_d = 1'b0;
                    en_ack_d  = 1'b0;
                    hcnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/clock_buf_ctrl.md
CLOCK_BUF_CTRL -- requirements
Module: clock_buf_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 4, giving the divide-select width.
REQ-002 SHALL have port clk  input  1  block clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en_req  input  1  requester level: 1 = run divided clock, 0 = stop.
REQ-005 SHALL have port div_sel  input  DIV_W  half-period select; half-period = div_sel+1 clk cycles.
REQ-006 SHALL have port clk_out  output  1  registered divided clock, driven to the clock buffer.
REQ-007 SHALL have port en_ack  output  1  clock-running acknowledge.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port rise_cnt  output  8  count of clk_out rising edges since the last start.

Function
REQ-010 SHALL implement states IDLE, RUN, STOP, encoded in a registered state variable.
REQ-011 SHALL, in IDLE with en_req=1 at an edge, latch div_sel into div_q, clear hcnt and rise_cnt, and enter RUN; clk_out stays 0.
REQ-012 SHALL, in RUN and STOP, increment hcnt each cycle; when hcnt==div_q, clear hcnt and toggle clk_out.
REQ-013 SHALL make the first clk_out rise occur div_q+1 cycles after the RUN entry edge; period 2*(div_q+1), duty exactly 50%.
REQ-014 SHALL set en_ack on the same edge as the first clk_out rise after RUN entry.
REQ-015 SHALL increment rise_cnt on every edge where clk_out goes 0->1, wrapping 255->0.
REQ-016 SHALL ignore div_sel changes outside IDLE; div_q changes only on IDLE->RUN.
REQ-017 SHALL, in RUN with en_req=0 at an edge, enter STOP without altering clk_out or hcnt.
REQ-018 SHALL, in STOP with clk_out=1, complete the high phase, then toggle clk_out to 0 and enter IDLE on that edge.
REQ-019 SHALL, in STOP with clk_out=0, enter IDLE on the next edge with clk_out held at 0.
REQ-020 SHALL never truncate a high phase; every clk_out high pulse lasts exactly div_q+1 cycles.
REQ-021 SHALL clear en_ack and hcnt on the edge that enters IDLE; rise_cnt holds its value in IDLE.
REQ-022 SHALL ignore en_req re-assertion during STOP; STOP completes, and IDLE then restarts normally per REQ-011.
REQ-023 SHALL handle en_req dropping before the first rise: RUN->STOP with clk_out=0, then IDLE with no pulse emitted and en_ack never set.
REQ-024 SHALL, for div_sel=0, produce clk_out toggling every cycle (clk/2).
REQ-025 SHALL assert busy combinationally from state (state != IDLE).

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE, clk_out=0, en_ack=0, hcnt=0, div_q=0, rise_cnt=0, independent of clk.
REQ-027 SHALL treat reset mid-RUN or mid-STOP identically, including truncating a high phase; no pulse resumes until a new en_req sampled after rst_n release.
REQ-028 SHALL sample en_req at the first clk edge after rst_n deassertion.

Verification
REQ-029 SHALL check start: div_sel=2, en_req 1 at edge k -> clk_out rises at edge k+3, en_ack rises at k+3, period 6 cycles, high 3 cycles.
REQ-030 SHALL check stop mid-high: div_sel=3, drop en_req 1 cycle into a high phase -> clk_out stays high 4 cycles total, then falls, with busy=0 and en_ack=0 on that edge.
REQ-031 SHALL check div_sel=0 and wrap: run 256 rises -> clk_out period 2 cycles, rise_cnt reads 0 after rise 256.
REQ-032 SHALL check div_sel change while RUN: 1->5 -> period stays 4 cycles; after stop and restart, period becomes 12 cycles.
REQ-033 SHALL check async reset mid-high: rst_n low between clk edges -> clk_out, en_ack, and busy are 0 before the next edge.
REQ-034 SHALL check early drop: en_req pulsed 1 cycle with div_sel=4 -> no clk_out pulse, en_ack stays 0, busy returns to 0 within 2 cycles.
